// File: rtl/mips_pkg.sv
// Shared MIPS core types and register index constants.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;

  typedef logic [ADDR_W-1:0] regidx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mips_regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, issue beats writeback.
module mips_regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] waddr1,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (issue_en && issue_addr == ADDR_W'(i)) begin
        pending_d[i] = 1'b1;
      end else if ((wen0 && waddr0 == ADDR_W'(i)) ||
                   (wen1 && waddr1 == ADDR_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (ZERO_REG != 0 && i == REG_ZERO) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port register file: registered reads with write-first bypass,
// two prioritised write ports, scoreboard and a registered debug tap.
module mips_regfile_mp
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int TAP_IDX  = REG_V0,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wen0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     wen1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [NUM_REGS-1:0]      pending,
  output logic [DATA_W-1:0]        register_v0
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] register_v0_q;
  logic [DATA_W-1:0] register_v0_d;

  // Next-state storage doubles as the bypass source for every reader.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!(ZERO_REG != 0 && i == REG_ZERO)) begin
        if (wen1 && waddr1 == ADDR_W'(i)) begin
          regs_d[i] = wdata1;
        end else if (wen0 && waddr0 == ADDR_W'(i)) begin
          regs_d[i] = wdata0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [DATA_W-1:0] rd_q;
      logic [DATA_W-1:0] rd_d;

      always_comb begin
        rd_d = regs_d[rd_addr[k*ADDR_W +: ADDR_W]];
      end

      always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_d;
        end
      end

      assign rd_data[k*DATA_W +: DATA_W] = rd_q;
    end
  endgenerate

  always_comb begin
    register_v0_d = regs_d[ADDR_W'(TAP_IDX)];
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      register_v0_q <= '0;
    end else begin
      register_v0_q <= register_v0_d;
    end
  end

  assign register_v0 = register_v0_q;

  mips_regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .RESET      (RESET),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wen0       (wen0),
    .waddr0     (waddr0),
    .wen1       (wen1),
    .waddr1     (waddr1),
    .pending    (pending)
  );

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed self-checking bench for mips_regfile_mp.
module tb_mips_regfile_mp;

  logic        clk;
  logic        RESET;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wen0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic        wen1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [31:0] pending;
  logic [31:0] register_v0;

  int n_pass;
  int n_total;

  mips_regfile_mp dut (
    .clk         (clk),
    .RESET       (RESET),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wen0        (wen0),
    .waddr0      (waddr0),
    .wdata0      (wdata0),
    .wen1        (wen1),
    .waddr1      (waddr1),
    .wdata1      (wdata1),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .pending     (pending),
    .register_v0 (register_v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
    wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
    issue_en = 1'b0; issue_addr = '0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    RESET = 1'b1;
    idle();
    set_rd(5'd5, 5'd0);
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    tick();
    tick();
    chk("rst_rd0", rd_data[31:0], 32'h0);
    chk("rst_rd1", rd_data[63:32], 32'h0);
    chk("rst_pend", pending, 32'h0);
    chk("rst_v0", register_v0, 32'h0);

    RESET = 1'b0;
    idle();
    set_rd(5'd5, 5'd0);
    tick();
    chk("post_rst_r5", rd_data[31:0], 32'h0);

    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h12345678;
    tick();
    idle();
    set_rd(5'd3, 5'd4);
    tick();
    chk("basic_r3", rd_data[31:0], 32'h12345678);
    chk("basic_r4", rd_data[63:32], 32'h0);

    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111;
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222;
    set_rd(5'd7, 5'd3);
    tick();
    chk("byp_prio", rd_data[31:0], 32'h2222);
    idle();
    set_rd(5'd3, 5'd7);
    tick();
    chk("r7_later", rd_data[63:32], 32'h2222);
    chk("r3_hold", rd_data[31:0], 32'h12345678);

    wen0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hAAAA0000;
    wen1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'hBBBB0000;
    set_rd(5'd10, 5'd11);
    tick();
    chk("dual_byp0", rd_data[31:0], 32'hAAAA0000);
    chk("dual_byp1", rd_data[63:32], 32'hBBBB0000);
    idle();
    tick();
    chk("dual_r10", rd_data[31:0], 32'hAAAA0000);
    chk("dual_r11", rd_data[63:32], 32'hBBBB0000);

    wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_addr = 5'd0;
    set_rd(5'd3, 5'd0);
    tick();
    chk("zero_byp", rd_data[63:32], 32'h0);
    chk("zero_pend", {31'b0, pending[0]}, 32'h0);
    idle();
    tick();
    chk("zero_later", rd_data[63:32], 32'h0);

    issue_en = 1'b1; issue_addr = 5'd9;
    tick();
    chk("sb_set", {31'b0, pending[9]}, 32'h1);
    chk("sb_vec", pending, 32'h0000_0200);
    wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
    tick();
    chk("sb_set_prio", {31'b0, pending[9]}, 32'h1);
    idle();
    wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h9A;
    tick();
    chk("sb_clr", {31'b0, pending[9]}, 32'h0);
    idle();
    wen0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h8;
    tick();
    chk("sb_nonpend_wr", pending, 32'h0);

    idle();
    wen0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'hCAFE;
    issue_en = 1'b1; issue_addr = 5'd12;
    set_rd(5'd9, 5'd2);
    tick();
    chk("tap_byp", register_v0, 32'hCAFE);
    chk("tap_rd1", rd_data[63:32], 32'hCAFE);
    chk("pend12", pending, 32'h0000_1000);
    idle();
    #2;
    RESET = 1'b1;
    #1;
    chk("async_v0", register_v0, 32'h0);
    chk("async_pend", pending, 32'h0);
    chk("async_rd1", rd_data[63:32], 32'h0);
    #1;
    RESET = 1'b0;
    tick();
    chk("after_rst_v0", register_v0, 32'h0);
    chk("after_rst_r9", rd_data[31:0], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_regfile_mp.md
Name: mips_regfile_mp

Overview:
- Parametrised multi-port successor to the single-issue CPU register file.
- Provides NUM_RD registered read ports, two prioritised write ports and write-to-read bypass.
- Also provides an optional hardwired zero register, a per-register pending-write scoreboard for hazard detection, and a registered $v0 debug tap.
- Sits between decode (read/issue) and writeback (write) in the pipelined MIPS core.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count (power of two, >= 4)
- ADDR_W, $clog2(NUM_REGS), address width (derived; not to be overridden)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never pending
- TAP_IDX, 2, index mirrored on register_v0

Ports:
- clk  in  1  clock, rising-edge
- RESET  in  1  asynchronous active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, port k at [k*DATA_W +: DATA_W]
- wen0  in  1  write enable, port 0 (e.g. ALU writeback)
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- wen1  in  1  write enable, port 1 (e.g. load writeback), priority port
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- issue_en  in  1  marks issue_addr as having an outstanding producer
- issue_addr  in  ADDR_W  destination of newly issued instruction
- pending  out  NUM_REGS  registered scoreboard, bit i = write to reg i outstanding
- register_v0  out  DATA_W  registered copy of reg TAP_IDX

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (RESET); the clock and reset names follow the codebase's existing register file.
- Reset:
  - While RESET=1: all storage, rd_data, pending and register_v0 are 0, asynchronously.
  - Reset asserted mid-operation discards in-flight writes and issues that same cycle.
  - First valid write is on the first rising edge with RESET=0.
- Read latency is 1 cycle: rd_data[k] at edge N+1 reflects rd_addr[k] sampled at edge N.
- Bypass (write-first):
  - If a write to rd_addr[k] is accepted at the same edge, rd_data[k] returns the new write data, not the stale value.
  - If both ports write that address, it returns wdata1.
- Write rules:
  - The storage update is committed at the edge.
  - wen0 and wen1 to different addresses: both commit.
  - Same address: port 1 wins, port 0 is dropped.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including under bypass.
  - pending[0] is held at 0.
- ZERO_REG=0: register 0 behaves like any other register.
- Scoreboard, per register i, evaluated at each edge:
  - set = issue_en && issue_addr==i
  - clr = (wen0 && waddr0==i) || (wen1 && waddr1==i)
  - set has priority over clr: a new producer issued in the same cycle as the old producer's writeback leaves the bit set.
  - Otherwise clr clears the bit; with neither, the bit holds.
  - Issuing to an already-pending register keeps it at 1; no counting.
  - A write to a non-pending register is legal and leaves the bit at 0.
- register_v0 is registered with the same bypass rule as the read ports: a 1-cycle-late view of reg TAP_IDX including a same-edge write.
- Out-of-range indices cannot occur (NUM_REGS is a power of two).
- No X propagation is permitted on outputs after reset; storage is fully reset.

Decomposition:
- Shared package mips_pkg:
  - REG_ZERO and REG_V0 index constants
  - a regidx_t typedef (ADDR_W-bit) and a word_t typedef (DATA_W-bit), for use by decode and hazard units
- One natural sub-module, mips_regfile_scoreboard:
  - contains the NUM_REGS-bit pending vector with set/clear priority logic
  - is instantiated once
- Read ports, bypass muxes and storage stay in the top via a generate loop over NUM_RD.

Test Plan:
- Reset, then read all: assert RESET, write 0xDEADBEEF to r5, read r5 and r0 -> rd_data=0, pending=0, register_v0=0 throughout. Release RESET; next-cycle read of r5 -> 0.
- Basic write/read plus latency:
  - cycle 0: wen0 r3=0x12345678
  - cycle 1: rd_addr[0]=r3
  - cycle 2: rd_data[0]=0x12345678; rd_data[1] on r4 = 0
- Bypass and port priority: same edge wen0 r7=0x1111, wen1 r7=0x2222, rd_addr[0]=r7 -> next cycle rd_data[0]=0x2222; r7 read again later = 0x2222.
- Zero register: wen1 r0=0xFFFFFFFF with rd_addr[1]=r0 and issue_en r0 -> rd_data[1]=0 both that cycle and later; pending[0]=0.
- Scoreboard:
  - issue_en r9 -> pending[9]=1
  - wen0 r9 with simultaneous issue_en r9 -> pending[9] stays 1
  - later wen1 r9 alone -> pending[9]=0
- Tap and async reset mid-op:
  - wen0 r2=0xCAFE -> register_v0=0xCAFE one edge later
  - pulse RESET between edges -> register_v0 and pending drop to 0 immediately, without waiting for a clock edge
